// File: rtl/serial_sub_alu_pkg.sv
// Shared definitions for the bit-serial subtract/compare unit.
// Optional add mode is enabled by defining SERIAL_ADD_MODE_EN.
package serial_sub_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

endpackage

// File: rtl/serial_sub_alu_sub_bit_cell.sv
// Single full-adder cell with optional inversion of the b operand.
module sub_bit_cell
    import serial_sub_alu_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic inv_b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic b_eff_s;

    assign b_eff_s = b ^ inv_b;
    assign s       = a ^ b_eff_s ^ cin;
    assign cout    = (a & b_eff_s) | (a & cin) | (b_eff_s & cin);

endmodule

// File: rtl/serial_sub_alu.sv
// Bit-serial two's-complement subtractor: one result bit per clock, flags held until the next op.
// Define SERIAL_ADD_MODE_EN to add an 'op' port selecting add (1) or subtract (0).
module serial_sub_alu
    import serial_sub_alu_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             c_flag,
    output logic             overflow,
    output logic             zero
);

    state_t             state_r;
    state_t             state_nx_s;
    logic               accept_s;
    logic               last_s;
    logic               op_s;
    logic               op_r;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   res_r;
    logic [WIDTH-1:0]   res_nx_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               sum_s;
    logic               cout_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   diff_r;
    logic               c_flag_r;
    logic               overflow_r;
    logic               zero_r;

`ifdef SERIAL_ADD_MODE_EN
    assign op_s = op;
`else
    assign op_s = OP_SUB;
`endif

    sub_bit_cell u_cell (
        .a     (a_sr_r[0]),
        .b     (b_sr_r[0]),
        .inv_b (op_r == OP_SUB),
        .cin   (carry_r),
        .s     (sum_s),
        .cout  (cout_s)
    );

    assign last_s   = (state_r == RUN) && (cnt_r == CNT_W'(WIDTH - 1));
    assign res_nx_s = {sum_s, res_r[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; a start during DONE is accepted just like in IDLE.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nx_s = RUN;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RUN;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Serial datapath and result/flag registers, updated only when the final bit lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r       <= OP_SUB;
            a_sr_r     <= {WIDTH{1'b0}};
            b_sr_r     <= {WIDTH{1'b0}};
            res_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            carry_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            diff_r     <= {WIDTH{1'b0}};
            c_flag_r   <= 1'b0;
            overflow_r <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            done_r <= last_s;
            if (accept_s) begin
                a_sr_r  <= a;
                b_sr_r  <= b;
                op_r    <= op_s;
                carry_r <= (op_s == OP_SUB);
                cnt_r   <= {CNT_W{1'b0}};
                busy_r  <= 1'b1;
            end else if (state_r == RUN) begin
                a_sr_r  <= a_sr_r >> 1;
                b_sr_r  <= b_sr_r >> 1;
                res_r   <= res_nx_s;
                carry_r <= cout_s;
                cnt_r   <= cnt_r + CNT_W'(1);
                if (last_s) begin
                    // carry_r still holds the carry into the MSB at this edge.
                    busy_r     <= 1'b0;
                    diff_r     <= res_nx_s;
                    c_flag_r   <= (op_r == OP_SUB) ? ~cout_s : cout_s;
                    overflow_r <= carry_r ^ cout_s;
                    zero_r     <= (res_nx_s == {WIDTH{1'b0}});
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign diff     = diff_r;
    assign c_flag   = c_flag_r;
    assign overflow = overflow_r;
    assign zero     = zero_r;

endmodule

// File: doc/serial_sub_alu.md
Name: serial_sub_alu

Overview:
- Bit-serial two's-complement subtractor for the multicycle CPU datapath; computes a − b one bit per clock through a single full-adder cell.
- Uses b inverted and initial carry-in of 1.
- Pairs with the team's ripple adder path, giving the ALU a low-area subtract/compare unit with a start/done handshake.
- Result, borrow, overflow and zero flags are registered and held until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- a  input  WIDTH  minuend, latched on accepted start.
- b  input  WIDTH  subtrahend, latched on accepted start.
- busy  output  1  high from the edge that accepts start until the edge that asserts done.
- done  output  1  one-cycle pulse; result and flags valid from this cycle on.
- diff  output  WIDTH  a − b mod 2^WIDTH.
- c_flag  output  1  borrow: 1 when unsigned a < b.
- overflow  output  1  signed overflow.
- zero  output  1  diff == 0.

Behaviour:
- Reset (synchronous, active-high) clears everything: state=IDLE, busy=0, done=0, diff=0, c_flag=0, overflow=0, zero=0, counter=0, carry=0. Reset wins over every other input, including mid-RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at an edge:
  - latch a and b into shift registers;
  - carry←1, count←0, state←RUN, busy←1.
- RUN, each edge:
  - bit cell computes s = a_sr[0] ^ ~b_sr[0] ^ carry, and the matching carry-out;
  - s shifts into the result register from the MSB; a_sr and b_sr shift right; carry←cout; count++.
  - On the edge where count==WIDTH−1, before updating carry, record carry_into_msb = current carry. Then state←DONE.
- DONE, one cycle:
  - done=1, busy=0;
  - diff = result register;
  - c_flag = ~final_carry;
  - overflow = carry_into_msb ^ final_carry;
  - zero = (result==0).
  - Next edge → IDLE. A start seen during DONE is accepted exactly as in IDLE, allowing back-to-back operations.
- Latency: done is high in the cycle after the (WIDTH+1)-th edge counted from the accepting edge, i.e. WIDTH+1 edges after start is sampled.
- start while busy is ignored. Operand inputs may change freely after acceptance.
- diff and flags change only on the DONE-entry edge or on reset; they are held stable otherwise.

Optional Feature:
- Macro: SERIAL_ADD_MODE_EN.
- With the macro defined:
  - extra input port op (1 bit), latched on start; 0 = subtract, 1 = add;
  - add mode uses b uninverted with initial carry 0;
  - c_flag = carry-out (unsigned overflow);
  - overflow uses the same MSB-carry rule.
- Without the macro: no op port; the block is subtract-only exactly as specified above.

Decomposition:
- Shared package:
  - state enum (IDLE, RUN, DONE);
  - default WIDTH constant;
  - op encoding constants (OP_SUB=0, OP_ADD=1).
- One natural sub-module: sub_bit_cell, a combinational 1-bit full adder with an invert-b control. The top instantiates it once.

Test Plan (WIDTH=8):
- a=0x05, b=0x03, start pulse → done exactly 9 edges after start sample; diff=0x02, c_flag=0, overflow=0, zero=0.
- a=0x03, b=0x05 → diff=0xFE, c_flag=1, overflow=0, zero=0.
- a=0x80, b=0x01 → diff=0x7F, c_flag=0, overflow=1. Also a=0x7F, b=0xFF → diff=0x80, c_flag=1, overflow=1.
- a=0x2A, b=0x2A → diff=0x00, zero=1, c_flag=0.
- start re-pulsed with new operands mid-RUN → ignored, first result delivered. Reset asserted at RUN cycle 4 → next cycle all outputs 0, busy=0, no done pulse. start held high through DONE → second op accepted back-to-back.
- SERIAL_ADD_MODE_EN, op=1, a=0x7F, b=0x01 → diff=0x80, c_flag=0, overflow=1. Then a=0xFF, b=0x01 → diff=0x00, c_flag=1, zero=1.
